// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID opcode into WB/M/EX bundles, carries them
// through ID/EX, EX/MEM, MEM/WB, and handles load-use stalls, branch flush and hold.
module pipe_ctrl_unit #(
  parameter int unsigned ALUOP_W = 6,
  parameter int unsigned REG_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  ex_rt,
  input  logic               branch_taken,
  input  logic               hold,
  output logic [ALUOP_W+1:0] ex_ctrl,
  output logic [2:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               illegal_op
);

  localparam int unsigned EX_W = ALUOP_W + 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned WB_W = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  if (ALUOP_W < 3) begin : g_cfg_check
    $error("pipe_ctrl_unit: ALUOP_W must be at least 3");
  end

  logic [EX_W-1:0] dec_ex;
  logic [M_W-1:0]  dec_m;
  logic [WB_W-1:0] dec_wb;
  logic            dec_ill;
  logic            load_use;

  logic [EX_W-1:0] idex_ex_q, idex_ex_d;
  logic [M_W-1:0]  idex_m_q, idex_m_d;
  logic [WB_W-1:0] idex_wb_q, idex_wb_d;
  logic            idex_ill_q, idex_ill_d;
  logic [M_W-1:0]  exmem_m_q, exmem_m_d;
  logic [WB_W-1:0] exmem_wb_q, exmem_wb_d;
  logic [WB_W-1:0] memwb_wb_q, memwb_wb_d;

  // ID-stage decode; ex bundle is {ALUSrc, RegDst, ALUOp}
  always_comb begin
    dec_ex  = '0;
    dec_m   = '0;
    dec_wb  = '0;
    dec_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_wb = 2'b01;
        dec_ex = {1'b0, 1'b1, ALUOP_W'(3'd0)};
      end
      OP_LW: begin
        dec_wb = 2'b11;
        dec_m  = 3'b010;
        dec_ex = {1'b1, 1'b0, ALUOP_W'(3'd1)};
      end
      OP_BNE: begin
        dec_m  = 3'b100;
        dec_ex = {1'b0, 1'b0, ALUOP_W'(3'd2)};
      end
      OP_BEQ: begin
        dec_m  = 3'b100;
        dec_ex = {1'b0, 1'b0, ALUOP_W'(3'd3)};
      end
      OP_SW: begin
        dec_m  = 3'b001;
        dec_ex = {1'b1, 1'b0, ALUOP_W'(3'd4)};
      end
      OP_ADDI: begin
        dec_wb = 2'b01;
        dec_ex = {1'b1, 1'b0, ALUOP_W'(3'd5)};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Load in EX whose destination feeds the ID instruction; r0 never hazards
  always_comb begin
    load_use = idex_m_q[1] && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

  // Pipeline control: rst > hold > branch flush > load-use > advance
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_ex_d  = dec_ex;
    idex_m_d   = dec_m;
    idex_wb_d  = dec_wb;
    idex_ill_d = dec_ill;
    exmem_m_d  = idex_m_q;
    exmem_wb_d = idex_wb_q;
    memwb_wb_d = exmem_wb_q;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_ex_d  = idex_ex_q;
      idex_m_d   = idex_m_q;
      idex_wb_d  = idex_wb_q;
      idex_ill_d = idex_ill_q;
      exmem_m_d  = exmem_m_q;
      exmem_wb_d = exmem_wb_q;
      memwb_wb_d = memwb_wb_q;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_ex_d  = '0;
      idex_m_d   = '0;
      idex_wb_d  = '0;
      idex_ill_d = 1'b0;
      exmem_m_d  = '0;
      exmem_wb_d = '0;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_ex_d  = '0;
      idex_m_d   = '0;
      idex_wb_d  = '0;
      idex_ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex_q  <= '0;
      idex_m_q   <= '0;
      idex_wb_q  <= '0;
      idex_ill_q <= 1'b0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
    end else begin
      idex_ex_q  <= idex_ex_d;
      idex_m_q   <= idex_m_d;
      idex_wb_q  <= idex_wb_d;
      idex_ill_q <= idex_ill_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
    end
  end

  assign ex_ctrl    = idex_ex_q;
  assign illegal_op = idex_ill_q;
  assign mem_ctrl   = exmem_m_q;
  assign wb_ctrl    = memwb_wb_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: driver pushes model expectations per cycle,
// monitor pops and compares on the falling edge.
module tb_pipe_ctrl_unit;
  localparam int unsigned ALUOP_W = 6;
  localparam int unsigned REG_AW  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [5:0]        opcode = '0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic              branch_taken = 1'b0, hold = 1'b0;
  logic [ALUOP_W+1:0] ex_ctrl;
  logic [2:0]        mem_ctrl;
  logic [1:0]        wb_ctrl;
  logic              pc_write, ifid_write, ifid_flush, illegal_op;

  pipe_ctrl_unit #(.ALUOP_W(ALUOP_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .hold(hold),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_SW = 6'b101011, OP_ADDI = 6'b001000;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        alusrc;
    logic        regdst;
    int unsigned aluop;
    logic        ill;
  } bundle_t;

  typedef struct {
    logic [7:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       ill;
    logic       pcw;
    logic       ifw;
    logic       ifw_chk;
    logic       flush;
  } exp_t;

  bundle_t pipe[$];   // [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
  exp_t    exp_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  function automatic bundle_t zero_b();
    bundle_t b;
    b.wb = 2'b00; b.m = 3'b000; b.alusrc = 1'b0; b.regdst = 1'b0; b.aluop = 0; b.ill = 1'b0;
    return b;
  endfunction

  function automatic bundle_t decode(input logic [5:0] op);
    bundle_t b;
    b = zero_b();
    case (op)
      OP_R:    begin b.wb = 2'b01; b.regdst = 1'b1; b.aluop = 0; end
      OP_LW:   begin b.wb = 2'b11; b.m = 3'b010; b.alusrc = 1'b1; b.aluop = 1; end
      OP_BNE:  begin b.m = 3'b100; b.aluop = 2; end
      OP_BEQ:  begin b.m = 3'b100; b.aluop = 3; end
      OP_SW:   begin b.m = 3'b001; b.alusrc = 1'b1; b.aluop = 4; end
      OP_ADDI: begin b.wb = 2'b01; b.alusrc = 1'b1; b.aluop = 5; end
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  task automatic reset_model();
    pipe.delete();
    repeat (3) pipe.push_back(zero_b());
  endtask

  // One cycle: drive inputs after the edge, record expectations, advance the model
  task automatic step(input logic r, input logic h, input logic b, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    exp_t e;
    logic lu;
    @(posedge clk);
    #1;
    rst = r; hold = h; branch_taken = b; opcode = op; id_rs = rs; id_rt = rt; ex_rt = ert;
    e.ex  = {pipe[0].alusrc, pipe[0].regdst, 6'(pipe[0].aluop)};
    e.ill = pipe[0].ill;
    e.mem = pipe[1].m;
    e.wb  = pipe[2].wb;
    lu = pipe[0].m[1] && (ert != 0) && ((ert == rs) || (ert == rt));
    e.ifw_chk = 1'b1;
    if (r || h) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b0;
    end else if (b) begin
      e.pcw = 1'b1; e.ifw = 1'b0; e.ifw_chk = 1'b0; e.flush = 1'b1;
    end else if (lu) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b0;
    end else begin
      e.pcw = 1'b1; e.ifw = 1'b1; e.flush = 1'b0;
    end
    exp_q.push_back(e);
    if (r) begin
      reset_model();
    end else if (!h) begin
      if (b) begin
        pipe.push_front(zero_b());
        void'(pipe.pop_back());
        pipe[1] = zero_b();
      end else begin
        pipe.push_front(lu ? zero_b() : decode(op));
        void'(pipe.pop_back());
      end
    end
  endtask

  task automatic adv(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] ert);
    step(1'b0, 1'b0, 1'b0, op, rs, rt, ert);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_ctrl", 8'(ex_ctrl), e.ex);
        chk("mem_ctrl", 8'(mem_ctrl), 8'(e.mem));
        chk("wb_ctrl", 8'(wb_ctrl), 8'(e.wb));
        chk("illegal_op", 8'(illegal_op), 8'(e.ill));
        chk("pc_write", 8'(pc_write), 8'(e.pcw));
        chk("ifid_flush", 8'(ifid_flush), 8'(e.flush));
        if (e.ifw_chk) chk("ifid_write", 8'(ifid_write), 8'(e.ifw));
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_BNE;
    ops[3] = OP_BEQ; ops[4] = OP_SW; ops[5] = OP_ADDI;
    reset_model();

    repeat (2) step(1'b1, 1'b0, 1'b0, OP_R, 0, 0, 0);
    // decode table back to back
    adv(OP_R, 0, 0, 0); adv(OP_LW, 0, 0, 0); adv(OP_SW, 0, 0, 0);
    adv(OP_BEQ, 0, 0, 0); adv(OP_BNE, 0, 0, 0); adv(OP_ADDI, 0, 0, 0);
    repeat (4) adv(OP_R, 0, 0, 0);
    // load-use on rs, then the same with r0 which must not stall
    adv(OP_LW, 1, 2, 0); adv(OP_R, 5, 1, 5); adv(OP_R, 5, 1, 5);
    repeat (3) adv(OP_R, 0, 0, 0);
    adv(OP_LW, 1, 2, 0); adv(OP_R, 0, 0, 0);
    repeat (3) adv(OP_R, 0, 0, 0);
    // beq resolves taken in MEM
    adv(OP_BEQ, 0, 0, 0); adv(OP_ADDI, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, OP_R, 0, 0, 0);
    repeat (3) adv(OP_R, 0, 0, 0);
    // flush and load-use together
    adv(OP_SW, 0, 0, 0); adv(OP_LW, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, OP_R, 7, 3, 7);
    repeat (3) adv(OP_R, 0, 0, 0);
    // hold mid-stream, then reset during hold
    adv(OP_R, 0, 0, 0); adv(OP_LW, 0, 0, 0); adv(OP_ADDI, 0, 0, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 6'($urandom), 0, 0, 0);
    adv(OP_SW, 0, 0, 0); adv(OP_BEQ, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, OP_R, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, OP_R, 0, 0, 0);
    repeat (3) adv(OP_R, 0, 0, 0);
    // undecoded opcode
    adv(6'h3f, 0, 0, 0);
    repeat (4) adv(OP_R, 0, 0, 0);

    // randomized traffic with small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
